// File: rtl/counter3_arbiter_pkg.sv
// Shared constants and state encoding for the two-requester grant-length arbiter.
package counter3_arbiter_pkg;

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/counter3_down.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module counter3_down #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count
);

  // Count register: load, else decrement while non-zero, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/counter3_arbiter.sv
// Round-robin arbiter granting one of two requesters for len+1 cycles,
// followed by a one-cycle gap before the next arbitration.
module counter3_arbiter
  import counter3_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W   = counter3_arbiter_pkg::CNT_W,
  parameter int unsigned NUM_REQ = counter3_arbiter_pkg::NUM_REQ
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [CNT_W-1:0]   len0,
  input  logic [CNT_W-1:0]   len1,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [CNT_W-1:0]   remain,
  output logic [NUM_REQ-1:0] done
);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 ptr_q, ptr_d;     // 1 = favour requester 1 on a tie
  logic                 win;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_W-1:0]     cnt_load_val;
  logic [CNT_W-1:0]     count;

  // Grant-length counter; cleared on exit from GRANT so it reads 0 elsewhere.
  counter3_down #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (count)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state, arbitration and counter control.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    done_d       = '0;
    ptr_d        = ptr_q;
    win          = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          // Requester 1 wins when alone or when it holds the tie pointer.
          win          = req[1] & (~req[0] | ptr_q);
          gnt_d        = '0;
          gnt_d[win]   = 1'b1;
          ptr_d        = ~win;
          cnt_load     = 1'b1;
          cnt_load_val = win ? len1 : len0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        if ((req & gnt_q) == '0) begin
          // Granted requester withdrew: abort without done.
          gnt_d    = '0;
          cnt_load = 1'b1;
          state_d  = GAP;
        end else if (count == '0) begin
          gnt_d   = '0;
          done_d  = gnt_q;
          state_d = GAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign remain = count;

endmodule

// File: tb/tb_counter3_arbiter.sv
// Directed-vector bench for counter3_arbiter with hand-computed expectations.
module tb_counter3_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [2:0] len0;
  logic [2:0] len1;
  logic [1:0] gnt;
  logic       busy;
  logic [2:0] remain;
  logic [1:0] done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  counter3_arbiter dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .len0   (len0),
    .len1   (len1),
    .gnt    (gnt),
    .busy   (busy),
    .remain (remain),
    .done   (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare all outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input logic [1:0] eg, input logic [1:0] ed,
                     input logic eb, input logic [2:0] er);
    @(posedge clk);
    #1;
    check({tag, ".gnt"},    32'(gnt),    32'(eg));
    check({tag, ".done"},   32'(done),   32'(ed));
    check({tag, ".busy"},   32'(busy),   32'(eb));
    check({tag, ".remain"}, 32'(remain), 32'(er));
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b11;
    len0  = 3'd0;
    len1  = 3'd0;

    // Reset held two cycles with both requests up.
    cyc("rst0", 2'b00, 2'b00, 1'b0, 3'd0);
    cyc("rst1", 2'b00, 2'b00, 1'b0, 3'd0);

    // Single requester 0, len 3: arbitrates in first cycle after reset.
    reset = 1'b0;
    req   = 2'b01;
    len0  = 3'd3;
    cyc("l3_g0", 2'b01, 2'b00, 1'b1, 3'd3);
    cyc("l3_g1", 2'b01, 2'b00, 1'b1, 3'd2);
    cyc("l3_g2", 2'b01, 2'b00, 1'b1, 3'd1);
    cyc("l3_g3", 2'b01, 2'b00, 1'b1, 3'd0);
    cyc("l3_gap", 2'b00, 2'b01, 1'b1, 3'd0);
    req = 2'b00;
    cyc("l3_idle", 2'b00, 2'b00, 1'b0, 3'd0);

    // Round robin from reset with both requests held, len 0.
    reset = 1'b1;
    req   = 2'b11;
    len0  = 3'd0;
    len1  = 3'd0;
    cyc("rr_rst", 2'b00, 2'b00, 1'b0, 3'd0);
    reset = 1'b0;
    cyc("rr_g0",   2'b01, 2'b00, 1'b1, 3'd0);
    cyc("rr_gap0", 2'b00, 2'b01, 1'b1, 3'd0);
    cyc("rr_idl0", 2'b00, 2'b00, 1'b0, 3'd0);
    cyc("rr_g1",   2'b10, 2'b00, 1'b1, 3'd0);
    cyc("rr_gap1", 2'b00, 2'b10, 1'b1, 3'd0);
    cyc("rr_idl1", 2'b00, 2'b00, 1'b0, 3'd0);
    cyc("rr_g2",   2'b01, 2'b00, 1'b1, 3'd0);
    cyc("rr_gap2", 2'b00, 2'b01, 1'b1, 3'd0);
    req = 2'b00;
    cyc("rr_end",  2'b00, 2'b00, 1'b0, 3'd0);

    // Requester 1, len 7, aborted after three grant cycles.
    req  = 2'b10;
    len1 = 3'd7;
    len0 = 3'd4;
    cyc("ab_g0", 2'b10, 2'b00, 1'b1, 3'd7);
    cyc("ab_g1", 2'b10, 2'b00, 1'b1, 3'd6);
    cyc("ab_g2", 2'b10, 2'b00, 1'b1, 3'd5);
    req = 2'b00;
    cyc("ab_gap", 2'b00, 2'b00, 1'b1, 3'd0);
    req = 2'b11;
    cyc("ab_idle", 2'b00, 2'b00, 1'b0, 3'd0);
    cyc("ab_next", 2'b01, 2'b00, 1'b1, 3'd4);

    // Reset mid-grant with remain 4.
    reset = 1'b1;
    cyc("mr_rst", 2'b00, 2'b00, 1'b0, 3'd0);
    reset = 1'b0;
    req   = 2'b00;
    cyc("mr_idle", 2'b00, 2'b00, 1'b0, 3'd0);

    // len0 changes mid-grant without effect.
    req  = 2'b01;
    len0 = 3'd2;
    cyc("lc_g0", 2'b01, 2'b00, 1'b1, 3'd2);
    len0 = 3'd6;
    cyc("lc_g1", 2'b01, 2'b00, 1'b1, 3'd1);
    cyc("lc_g2", 2'b01, 2'b00, 1'b1, 3'd0);
    cyc("lc_gap", 2'b00, 2'b01, 1'b1, 3'd0);
    req = 2'b00;
    cyc("lc_idle", 2'b00, 2'b00, 1'b0, 3'd0);

    // Lone requester 0 wins although the pointer favours requester 1.
    req  = 2'b01;
    len0 = 3'd0;
    cyc("sr_g0", 2'b01, 2'b00, 1'b1, 3'd0);
    cyc("sr_gap", 2'b00, 2'b01, 1'b1, 3'd0);
    req = 2'b00;
    cyc("sr_idle", 2'b00, 2'b00, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
